// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, SIMT reconvergence FSM states and the
// "no reconvergence point pending" marker.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam word_t SIMT_NO_SYNC = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        DIV_RC = 3'd1,
        DIV_NT = 3'd2,
        POP    = 3'd3,
        FAULT  = 3'd4
    } simt_ctrl_state_t;

endpackage

// File: rtl/simt_stack_if.sv
// Signal bundle between the reconvergence controller and the SIMT stack.
// The datapath side pushes/pops; the stack side reports its top entry and status.
interface simt_stack_if
    import cpu_types_pkg::*;
#(
    parameter int THREADS = 4
);
    logic [1:0]         pushEn;
    logic               popEn;
    word_t              newSync;
    word_t              newAddr;
    logic [THREADS-1:0] newMask;
    word_t              currentSync;
    word_t              currentAddr;
    logic [THREADS-1:0] currentMask;
    logic               overflow;
    logic               underflow;
    logic               isEmpty;

    modport datapath (
        output pushEn, popEn, newSync, newAddr, newMask,
        input  currentSync, currentAddr, currentMask, overflow, underflow, isEmpty
    );

    modport stack (
        input  pushEn, popEn, newSync, newAddr, newMask,
        output currentSync, currentAddr, currentMask, overflow, underflow, isEmpty
    );
endinterface

// File: rtl/simt_branch_classify.sv
// Classifies a resolved branch against the currently active lanes.
// Uniform-taken wins when both tests hold (only possible with an empty mask).
module simt_branch_classify #(
    parameter int THREADS = 4
) (
    input  logic [THREADS-1:0] brTaken,
    input  logic [THREADS-1:0] activeMask,
    output logic [THREADS-1:0] t,
    output logic               uniTaken,
    output logic               uniNotTaken,
    output logic               divergent
);
    // Only enabled lanes may vote on the branch outcome.
    for (genvar gi = 0; gi < THREADS; gi++) begin : g_lane
        assign t[gi] = brTaken[gi] & activeMask[gi];
    end

    assign uniTaken    = (t == activeMask);
    assign uniNotTaken = (t == '0) && !uniTaken;
    assign divergent   = !uniTaken && !uniNotTaken;
endmodule

// File: rtl/simt_reconv_ctrl.sv
// SIMT divergence / reconvergence controller. Splits divergent branches into
// two stack pushes, pops at reconvergence points, and redirects fetch.
module simt_reconv_ctrl
    import cpu_types_pkg::*;
#(
    parameter int          THREADS = 4,
    parameter logic [31:0] NO_SYNC = SIMT_NO_SYNC
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               brValid,
    input  logic [THREADS-1:0] brTaken,
    input  word_t              brTarget,
    input  word_t              brFallthru,
    input  word_t              brSync,
    input  word_t              fetchPc,
    input  logic               pcValid,
    output logic [THREADS-1:0] activeMask,
    output logic               pcOverride,
    output word_t              pcOverrideAddr,
    output logic               stall,
    output logic               fault,
    output logic [1:0]         pushEn,
    output logic               popEn,
    output word_t              newSync,
    output word_t              newAddr,
    output logic [THREADS-1:0] newMask,
    input  word_t              currentSync,
    input  word_t              currentAddr,
    input  logic [THREADS-1:0] currentMask,
    input  logic               overflow,
    input  logic               underflow,
    input  logic               isEmpty
);
    simt_ctrl_state_t   state_reg;
    logic [THREADS-1:0] active_mask_reg;
    word_t              active_sync_reg;
    logic [THREADS-1:0] br_t_reg;
    word_t              br_sync_reg;
    word_t              br_fallthru_reg;
    word_t              br_target_reg;

    logic [THREADS-1:0] t;
    logic               uni_taken;
    logic               uni_not_taken;
    logic               divergent;
    logic               sync_match;

    logic [1:0]         push_en_next;
    logic               pop_en_next;
    word_t              new_sync_next;
    word_t              new_addr_next;
    logic [THREADS-1:0] new_mask_next;

    // Stack-facing signals are gathered in the shared stack bundle.
    simt_stack_if #(.THREADS(THREADS)) stk_if ();

    assign stk_if.pushEn      = push_en_next;
    assign stk_if.popEn       = pop_en_next;
    assign stk_if.newSync     = new_sync_next;
    assign stk_if.newAddr     = new_addr_next;
    assign stk_if.newMask     = new_mask_next;
    assign stk_if.currentSync = currentSync;
    assign stk_if.currentAddr = currentAddr;
    assign stk_if.currentMask = currentMask;
    assign stk_if.overflow    = overflow;
    assign stk_if.underflow   = underflow;
    assign stk_if.isEmpty     = isEmpty;

    assign pushEn  = stk_if.pushEn;
    assign popEn   = stk_if.popEn;
    assign newSync = stk_if.newSync;
    assign newAddr = stk_if.newAddr;
    assign newMask = stk_if.newMask;

    simt_branch_classify #(.THREADS(THREADS)) u_classify (
        .brTaken     (brTaken),
        .activeMask  (active_mask_reg),
        .t           (t),
        .uniTaken    (uni_taken),
        .uniNotTaken (uni_not_taken),
        .divergent   (divergent)
    );

    // A branch in the same cycle takes priority over a reconvergence pop.
    assign sync_match = pcValid && (fetchPc == active_sync_reg) && !stk_if.isEmpty && !brValid;

    assign activeMask = active_mask_reg;

    // Controller state, active lane context and captured branch operands.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg       <= RUN;
            active_mask_reg <= '1;
            active_sync_reg <= NO_SYNC;
            br_t_reg        <= '0;
            br_sync_reg     <= '0;
            br_fallthru_reg <= '0;
            br_target_reg   <= '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (brValid) begin
                        br_t_reg        <= t;
                        br_sync_reg     <= brSync;
                        br_fallthru_reg <= brFallthru;
                        br_target_reg   <= brTarget;
                        if (divergent) state_reg <= DIV_RC;
                    end else if (sync_match) begin
                        state_reg <= POP;
                    end
                end
                DIV_RC: state_reg <= stk_if.overflow ? FAULT : DIV_NT;
                DIV_NT: begin
                    if (stk_if.overflow) begin
                        state_reg <= FAULT;
                    end else begin
                        active_mask_reg <= br_t_reg;
                        active_sync_reg <= br_sync_reg;
                        state_reg       <= RUN;
                    end
                end
                POP: begin
                    if (stk_if.underflow) begin
                        state_reg <= FAULT;
                    end else begin
                        active_mask_reg <= stk_if.currentMask;
                        active_sync_reg <= stk_if.currentSync;
                        state_reg       <= RUN;
                    end
                end
                FAULT:   state_reg <= FAULT;
                default: state_reg <= FAULT;
            endcase
        end
    end

    // Per-state outputs; everything is held low while reset is asserted so an
    // interrupted sequence cannot push or pop in the reset cycle.
    always_comb begin
        pcOverride     = 1'b0;
        pcOverrideAddr = '0;
        stall          = 1'b0;
        fault          = 1'b0;
        push_en_next   = 2'b00;
        pop_en_next    = 1'b0;
        new_sync_next  = '0;
        new_addr_next  = '0;
        new_mask_next  = '0;
        if (!RST) begin
            case (state_reg)
                RUN: begin
                    if (brValid) begin
                        if (uni_taken) begin
                            pcOverride     = 1'b1;
                            pcOverrideAddr = brTarget;
                        end else if (divergent) begin
                            stall = 1'b1;
                        end
                    end else if (sync_match) begin
                        stall = 1'b1;
                    end
                end
                DIV_RC: begin
                    stall         = 1'b1;
                    push_en_next  = 2'b01;
                    new_sync_next = active_sync_reg;
                    new_addr_next = br_sync_reg;
                    new_mask_next = active_mask_reg;
                end
                DIV_NT: begin
                    stall          = 1'b1;
                    push_en_next   = 2'b01;
                    new_sync_next  = br_sync_reg;
                    new_addr_next  = br_fallthru_reg;
                    new_mask_next  = active_mask_reg & ~br_t_reg;
                    pcOverride     = 1'b1;
                    pcOverrideAddr = br_target_reg;
                end
                POP: begin
                    stall          = 1'b1;
                    pop_en_next    = 1'b1;
                    pcOverride     = 1'b1;
                    pcOverrideAddr = stk_if.currentAddr;
                end
                FAULT: begin
                    stall = 1'b1;
                    fault = 1'b1;
                end
                default: begin
                    stall = 1'b1;
                    fault = 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_simt_reconv_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic against a queue-based reference of the controller and stack.
module tb_simt_reconv_ctrl;
    import cpu_types_pkg::*;

    localparam int          TH  = 4;
    localparam int          CAP = 8;
    localparam logic [31:0] NS  = 32'hFFFF_FFFF;

    logic          CLK = 1'b0;
    logic          RST;
    logic          brValid;
    logic [TH-1:0] brTaken;
    logic [31:0]   brTarget, brFallthru, brSync, fetchPc;
    logic          pcValid;
    logic [TH-1:0] activeMask;
    logic          pcOverride;
    logic [31:0]   pcOverrideAddr;
    logic          stall, fault;
    logic [1:0]    pushEn;
    logic          popEn;
    logic [31:0]   newSync, newAddr;
    logic [TH-1:0] newMask;
    logic [31:0]   currentSync, currentAddr;
    logic [TH-1:0] currentMask;
    logic          overflow, underflow, isEmpty;

    always #5 CLK = ~CLK;

    simt_reconv_ctrl #(.THREADS(TH), .NO_SYNC(NS)) dut (
        .CLK(CLK), .RST(RST), .brValid(brValid), .brTaken(brTaken),
        .brTarget(brTarget), .brFallthru(brFallthru), .brSync(brSync),
        .fetchPc(fetchPc), .pcValid(pcValid), .activeMask(activeMask),
        .pcOverride(pcOverride), .pcOverrideAddr(pcOverrideAddr),
        .stall(stall), .fault(fault), .pushEn(pushEn), .popEn(popEn),
        .newSync(newSync), .newAddr(newAddr), .newMask(newMask),
        .currentSync(currentSync), .currentAddr(currentAddr),
        .currentMask(currentMask), .overflow(overflow),
        .underflow(underflow), .isEmpty(isEmpty)
    );

    typedef struct {
        logic [31:0]   sync;
        logic [31:0]   addr;
        logic [TH-1:0] mask;
    } entry_t;

    // One pending stall cycle of a multi-cycle sequence.
    typedef struct {
        bit            pop;
        logic [31:0]   ns;
        logic [31:0]   na;
        logic [TH-1:0] nm;
        bit            ovr;
        logic [31:0]   oa;
        bit            upd;
        logic [TH-1:0] um;
        logic [31:0]   us;
    } rec_t;

    entry_t        stk[$];
    rec_t          plan[$];
    logic [TH-1:0] m_mask = '1;
    logic [31:0]   m_sync = NS;
    bit            m_fault = 1'b0;
    bit            inj_ovf = 1'b0, inj_unf = 1'b0;
    bit            act_div, act_pop;
    rec_t          r1, r2;
    int            checks = 0;
    int            passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic idle();
        RST = 0; brValid = 0; brTaken = '0; brTarget = '0; brFallthru = '0;
        brSync = '0; fetchPc = '0; pcValid = 0; inj_ovf = 0; inj_unf = 0;
    endtask

    task automatic drive_stack();
        isEmpty   = (stk.size() == 0);
        overflow  = (stk.size() >= CAP) || inj_ovf;
        underflow = (stk.size() == 0) || inj_unf;
        if (stk.size() == 0) begin
            currentSync = '0; currentAddr = '0; currentMask = '0;
        end else begin
            currentSync = stk[$].sync; currentAddr = stk[$].addr; currentMask = stk[$].mask;
        end
    endtask

    // Compute the required outputs for this cycle and compare every one.
    task automatic eval_cmp();
        logic [TH-1:0] t, e_nm;
        logic [31:0]   e_oa, e_ns, e_na;
        logic          e_ovr, e_stall, e_fault, e_pop;
        logic [1:0]    e_push;
        rec_t          r;
        drive_stack();
        #1;
        e_ovr = 0; e_oa = '0; e_stall = 0; e_fault = 0; e_pop = 0;
        e_push = 2'b00; e_ns = '0; e_na = '0; e_nm = '0;
        act_div = 0; act_pop = 0;
        if (RST) begin
        end else if (m_fault) begin
            e_stall = 1; e_fault = 1;
        end else if (plan.size() > 0) begin
            r = plan[0];
            e_stall = 1;
            if (r.pop) begin
                e_pop = 1; e_ovr = 1; e_oa = currentAddr;
            end else begin
                e_push = 2'b01; e_ns = r.ns; e_na = r.na; e_nm = r.nm;
                e_ovr = r.ovr; e_oa = r.oa;
            end
        end else if (brValid) begin
            t = brTaken & m_mask;
            if (t == m_mask) begin
                e_ovr = 1; e_oa = brTarget;
            end else if (t != '0) begin
                e_stall = 1; act_div = 1;
                r1 = '{pop: 0, ns: m_sync, na: brSync, nm: m_mask, ovr: 0, oa: '0,
                       upd: 0, um: '0, us: '0};
                r2 = '{pop: 0, ns: brSync, na: brFallthru, nm: m_mask & ~t, ovr: 1,
                       oa: brTarget, upd: 1, um: t, us: brSync};
            end
        end else if (pcValid && fetchPc == m_sync && stk.size() > 0) begin
            e_stall = 1; act_pop = 1;
        end
        chk("activeMask", activeMask, m_mask);
        chk("pcOverride", pcOverride, e_ovr);
        chk("pcOverrideAddr", pcOverrideAddr, e_oa);
        chk("stall", stall, e_stall);
        chk("fault", fault, e_fault);
        chk("pushEn", pushEn, e_push);
        chk("popEn", popEn, e_pop);
        chk("newSync", newSync, e_ns);
        chk("newAddr", newAddr, e_na);
        chk("newMask", newMask, e_nm);
    endtask

    // Clock edge: advance the reference, then return to the falling edge.
    task automatic advance();
        rec_t   r;
        entry_t e;
        @(posedge CLK);
        if (RST) begin
            m_mask = '1; m_sync = NS; m_fault = 0;
            plan.delete(); stk.delete();
        end else if (m_fault) begin
        end else if (plan.size() > 0) begin
            r = plan.pop_front();
            if (r.pop) begin
                if (underflow) begin
                    m_fault = 1; plan.delete();
                end else begin
                    e = stk.pop_back();
                    m_mask = e.mask; m_sync = e.sync;
                end
            end else if (overflow) begin
                m_fault = 1; plan.delete();
            end else begin
                stk.push_back('{sync: r.ns, addr: r.na, mask: r.nm});
                if (r.upd) begin
                    m_mask = r.um; m_sync = r.us;
                end
            end
        end else if (act_div) begin
            plan.push_back(r1); plan.push_back(r2);
        end else if (act_pop) begin
            plan.push_back('{pop: 1, ns: '0, na: '0, nm: '0, ovr: 0, oa: '0,
                             upd: 0, um: '0, us: '0});
        end
        @(negedge CLK);
    endtask

    task automatic step();
        eval_cmp();
        advance();
    endtask

    task automatic diverge(input logic [TH-1:0] tk, input logic [31:0] tg,
                           input logic [31:0] ft, input logic [31:0] sy);
        brValid = 1; brTaken = tk; brTarget = tg; brFallthru = ft; brSync = sy;
        eval_cmp();
        chk("div_stall0", stall, 1);
        advance();
        brValid = 0;
    endtask

    initial begin
        idle();
        RST = 1;
        @(negedge CLK);
        advance();
        RST = 0;

        // Reset values.
        eval_cmp();
        chk("rst_stall", stall, 0);
        chk("rst_push", pushEn, 0);
        chk("rst_mask", activeMask, 4'hF);
        chk("rst_fault", fault, 0);
        advance();
        $display("txn reset done");

        // Uniform taken branch: same-cycle redirect, no stall.
        brValid = 1; brTaken = 4'hF; brTarget = 32'h100;
        eval_cmp();
        chk("uni_ovr", pcOverride, 1);
        chk("uni_addr", pcOverrideAddr, 32'h100);
        chk("uni_stall", stall, 0);
        chk("uni_push", pushEn, 0);
        advance();
        idle();
        $display("txn uniform-taken branch");

        // Divergent branch: two pushes over three stall cycles.
        diverge(4'b0101, 32'h100, 32'h44, 32'h80);
        eval_cmp();
        chk("rc_push", pushEn, 2'b01);
        chk("rc_sync", newSync, NS);
        chk("rc_addr", newAddr, 32'h80);
        chk("rc_mask", newMask, 4'hF);
        chk("rc_stall", stall, 1);
        advance();
        eval_cmp();
        chk("nt_push", pushEn, 2'b01);
        chk("nt_sync", newSync, 32'h80);
        chk("nt_addr", newAddr, 32'h44);
        chk("nt_mask", newMask, 4'b1010);
        chk("nt_ovr", pcOverrideAddr, 32'h100);
        chk("nt_stall", stall, 1);
        advance();
        eval_cmp();
        chk("div_mask", activeMask, 4'b0101);
        chk("div_done_stall", stall, 0);
        advance();
        $display("txn divergent branch");

        // Two reconvergence pops.
        for (int k = 0; k < 2; k++) begin
            pcValid = 1; fetchPc = 32'h80;
            eval_cmp();
            chk("pop_stall0", stall, 1);
            advance();
            pcValid = 0;
            eval_cmp();
            chk("pop_en", popEn, 1);
            chk("pop_addr", pcOverrideAddr, (k == 0) ? 32'h44 : 32'h80);
            advance();
            eval_cmp();
            chk("pop_mask", activeMask, (k == 0) ? 32'hA : 32'hF);
            advance();
        end
        // activeSync is back at NO_SYNC with an empty stack: no pop.
        pcValid = 1; fetchPc = NS;
        eval_cmp();
        chk("empty_nopop", stall, 0);
        advance();
        idle();
        $display("txn reconvergence pops");

        // Branch and reconvergence match in the same cycle.
        diverge(4'b0101, 32'h100, 32'h44, 32'h80);
        step(); step();
        brValid = 1; brTaken = 4'b0101; brTarget = 32'h200; pcValid = 1; fetchPc = 32'h80;
        eval_cmp();
        chk("prio_ovr", pcOverrideAddr, 32'h200);
        chk("prio_stall", stall, 0);
        chk("prio_pop", popEn, 0);
        advance();
        brValid = 0;
        step(); step();
        idle();
        $display("txn branch over pop priority");

        // Reset in DIV_RC aborts the sequence.
        diverge(4'b0010, 32'h300, 32'h48, 32'h90);
        RST = 1;
        eval_cmp();
        chk("abort_push_rst", pushEn, 0);
        advance();
        RST = 0;
        eval_cmp();
        chk("abort_push", pushEn, 0);
        chk("abort_mask", activeMask, 4'hF);
        advance();
        $display("txn reset abort");

        // Overflow in DIV_NT: sticky fault until reset.
        diverge(4'b0101, 32'h100, 32'h44, 32'h80);
        step();
        inj_ovf = 1;
        step();
        inj_ovf = 0;
        for (int k = 0; k < 12; k++) begin
            eval_cmp();
            chk("flt_fault", fault, 1);
            chk("flt_stall", stall, 1);
            advance();
        end
        RST = 1;
        step();
        RST = 0;
        eval_cmp();
        chk("flt_clr", fault, 0);
        chk("flt_mask", activeMask, 4'hF);
        advance();
        $display("txn overflow fault");

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            RST        = ($urandom_range(0, 59) == 0);
            brValid    = ($urandom_range(0, 3) == 0);
            brTaken    = TH'($urandom);
            brTarget   = {22'd0, 8'($urandom), 2'b00};
            brFallthru = {22'd0, 8'($urandom), 2'b00};
            brSync     = 32'h800 + {26'd0, 4'($urandom_range(0, 7)), 2'b00};
            pcValid    = ($urandom_range(0, 1) == 1);
            fetchPc    = ($urandom_range(0, 2) == 0) ? m_sync : {22'd0, 8'($urandom), 2'b00};
            inj_ovf    = ($urandom_range(0, 49) == 0);
            inj_unf    = ($urandom_range(0, 49) == 0);
            step();
        end
        idle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/simt_reconv_ctrl.md
SIMT_RECONV_CTRL -- requirements
Module: simt_reconv_ctrl

Interface
REQ-001 The block SHALL have parameter THREADS, default 4, giving the number of SIMT lanes and the width of every mask.
REQ-002 The block SHALL have parameter NO_SYNC, default 32'hFFFFFFFF, meaning "no reconvergence point pending".
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous active-high reset.
- brValid  in  1  resolved branch, one-cycle pulse.
- brTaken  in  THREADS  per-lane taken.
- brTarget, brFallthru, brSync  in  32 each  taken PC, not-taken PC, reconvergence PC.
- fetchPc  in  32  PC being issued.
- pcValid  in  1  fetchPc is valid.
- activeMask  out  THREADS  lanes enabled.
- pcOverride  out  1  redirect fetch.
- pcOverrideAddr  out  32  redirect target.
- stall  out  1  freeze front end.
- fault  out  1  sticky stack error.
- pushEn  out  2  stack push.
- popEn  out  1  stack pop.
- newSync, newAddr  out  32 each  entry fields to push.
- newMask  out  THREADS  entry mask to push.
- currentSync, currentAddr  in  32 each  top-of-stack fields, combinational.
- currentMask  in  THREADS  top-of-stack mask.
- overflow, underflow, isEmpty  in  1 each  stack status.

Function
REQ-005 The block SHALL hold registers activeMask, activeSync and state, with state one of RUN, DIV_RC, DIV_NT, POP, FAULT.
REQ-006 In RUN with brValid, the block SHALL compute t = brTaken & activeMask; classify the branch as uniform-taken when t == activeMask, uniform-not-taken when t == 0, otherwise divergent.
REQ-007 On a uniform-taken branch, the block SHALL assert pcOverride with pcOverrideAddr = brTarget in the same cycle, with no stall and no push.
REQ-008 On a uniform-not-taken branch, the block SHALL assert no output and make no state change.
REQ-009 On a divergent branch, the block SHALL assert stall and go to DIV_RC.
REQ-010 In DIV_RC, the block SHALL assert stall and pushEn = 2'b01 with {newSync = activeSync, newAddr = brSync, newMask = activeMask}, then go to DIV_NT.
REQ-011 In DIV_NT, the block SHALL:
- assert stall and pushEn = 2'b01 with {newSync = brSync, newAddr = brFallthru, newMask = activeMask & ~t};
- assert pcOverride with pcOverrideAddr = brTarget;
- load activeMask <= t and activeSync <= brSync;
- go to RUN.
REQ-012 Branch operands (t, brSync, brFallthru, brTarget) SHALL be captured on the brValid cycle and used from those registers in DIV_RC and DIV_NT.
REQ-013 In RUN, when pcValid && fetchPc == activeSync && !isEmpty && !brValid, the block SHALL assert stall and go to POP; brValid has priority over this check.
REQ-014 In POP, the block SHALL:
- assert stall, popEn = 1 and pcOverride with pcOverrideAddr = currentAddr;
- load activeMask <= currentMask and activeSync <= currentSync;
- go to RUN.
The divergence sequence therefore costs 3 stall cycles, a pop 2 stall cycles, and a uniform branch 0.
REQ-015 The reconvergence match with isEmpty = 1 SHALL be ignored, with no pop.
REQ-016 brValid outside RUN SHALL be ignored.
REQ-017 When overflow is sampled high in DIV_RC or DIV_NT, or underflow in POP, the block SHALL go to FAULT.
REQ-018 In FAULT, the block SHALL hold fault = 1 and stall = 1, with no push or pop, until RST.
REQ-019 pushEn values other than 2'b00 and 2'b01 SHALL never be driven.
REQ-020 pushEn and popEn SHALL never be asserted in the same cycle.
REQ-021 All outputs not named active in a given state SHALL be 0.

Reset
REQ-022 While RST is high at a rising CLK edge, the block SHALL load state = RUN, activeMask = all ones, activeSync = NO_SYNC.
REQ-023 While RST is high at a rising CLK edge, the block SHALL clear the captured branch registers and the fault flag.
REQ-024 After the RST edge, outputs SHALL be pushEn = 0, popEn = 0, pcOverride = 0, stall = 0, fault = 0, and new* = 0.
REQ-025 RST asserted mid-sequence (DIV_RC, DIV_NT or POP) SHALL abort the sequence with no further push or pop; the stack is reset by the same RST.

Structure
REQ-026 The state enum simt_ctrl_state_t and the constant SIMT_NO_SYNC SHALL live in cpu_types_pkg; word_t comes from the same package.
REQ-027 The block SHALL connect to the stack through the datapath modport of simt_stack_if.
REQ-028 The branch classification SHALL be one combinational sub-module, simt_branch_classify (inputs brTaken, activeMask; outputs t, uniTaken, uniNotTaken, divergent).

Verification
REQ-029 After reset, brValid with brTaken = 4'b1111 and brTarget = 0x100 -> pcOverride = 1, addr 0x100, same cycle; stall = 0; no push.
REQ-030 With activeMask = 4'b1111, brValid with brTaken = 4'b0101, brTarget = 0x100, brFallthru = 0x44, brSync = 0x80 -> the following pushes occur:
- DIV_RC pushes {NO_SYNC, 0x80, 1111};
- DIV_NT pushes {0x80, 0x44, 1010}, then activeMask = 0101 and activeSync = 0x80;
- stall is high for 3 cycles.
REQ-031 Continuing, with fetchPc = 0x80 valid and top = {0x80, 0x44, 1010} -> popEn = 1, redirect to 0x44, activeMask = 1010; a second match pops to 0x80 with mask 1111 and activeSync = NO_SYNC.
REQ-032 In DIV_NT, drive overflow = 1 -> FAULT, fault = 1, stall = 1 held for 10+ cycles; RST returns the block to the reset values.
REQ-033 With brValid and fetchPc == activeSync in the same cycle -> the branch is handled first and no pop occurs that cycle; with RST asserted in DIV_RC -> no DIV_NT push follows.
